// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg: shared definitions for the HI/LO unit.
//   - op bit indices for the one-hot {mtlo,mthi,divu,div,multu,mult} op vector
//   - FSM state encoding
//   - field split of 64-bit multiplier/divider results into HI and LO
package hilo_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 6;

    localparam int unsigned OP_MULT  = 0;
    localparam int unsigned OP_MULTU = 1;
    localparam int unsigned OP_DIV   = 2;
    localparam int unsigned OP_DIVU  = 3;
    localparam int unsigned OP_MTHI  = 4;
    localparam int unsigned OP_MTLO  = 5;

    // 64-bit result layout: HI in the upper word, LO in the lower word
    localparam int unsigned RES_HI_MSB = 63;
    localparam int unsigned RES_HI_LSB = 32;
    localparam int unsigned RES_LO_MSB = 31;
    localparam int unsigned RES_LO_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    // Isolate the lowest set bit so a multi-hot op behaves as its lowest op
    function automatic logic [OP_W-1:0] op_lowest(input logic [OP_W-1:0] op);
        return op & OP_W'(~op + OP_W'(1));
    endfunction

endpackage

// File: rtl/hilo_unit.sv
// hilo_unit: EX-stage owner of the HI/LO architectural registers.
// Commits multiplier results and MTHI/MTLO in the accept cycle, sequences the
// handshaked divider through LAUNCH/WAIT, and drains an abandoned divide.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid, op, src1, src2 EX request (one-hot op, lowest bit wins)
//   cancel                   EX flush, aborts the current op
//   op_ready                 op completes this cycle (combinational)
//   hi_rdata, lo_rdata       committed HI/LO
//   busy                     unit not idle
//   mul_op, mul_src1/2       combinational multiplier request
//   mul_result               multiplier product {HI,LO}
//   div_op, dividend/divisor registered divider operands
//   div_in_valid             one-cycle divider launch
//   div_result               {remainder, quotient}
//   div_out_valid/ready      divider result handshake
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] HILO_RST = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            cancel,
    output logic            op_ready,
    output logic [XLEN-1:0] hi_rdata,
    output logic [XLEN-1:0] lo_rdata,
    output logic            busy,
    output logic [1:0]      mul_op,
    output logic [XLEN-1:0] mul_src1,
    output logic [XLEN-1:0] mul_src2,
    input  logic [63:0]     mul_result,
    output logic [1:0]      div_op,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    output logic            div_in_valid,
    input  logic [63:0]     div_result,
    input  logic            div_out_valid,
    output logic            div_out_ready
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] hi_q, lo_q, hi_d, lo_d;
    logic [OP_W-1:0] op_sel;
    logic            launch;

    assign op_sel   = op_lowest(op);
    assign mul_op   = {op_sel[OP_MULTU], op_sel[OP_MULT]};
    assign mul_src1 = src1;
    assign mul_src2 = src2;
    assign hi_rdata = hi_q;
    assign lo_rdata = lo_q;
    assign busy     = (state_q != ST_IDLE);

    // Next state, handshake strobes and HI/LO next values
    always_comb begin
        state_d       = state_q;
        op_ready      = 1'b0;
        div_in_valid  = 1'b0;
        div_out_ready = 1'b0;
        hi_d          = hi_q;
        lo_d          = lo_q;
        launch        = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid && !cancel) begin
                        if (op_sel[OP_MULT] || op_sel[OP_MULTU]) begin
                            op_ready = 1'b1;
                            hi_d     = mul_result[RES_HI_MSB:RES_HI_LSB];
                            lo_d     = mul_result[RES_LO_MSB:RES_LO_LSB];
                        end else if (op_sel[OP_DIV] || op_sel[OP_DIVU]) begin
                            launch  = 1'b1;
                            state_d = ST_LAUNCH;
                        end else if (op_sel[OP_MTHI]) begin
                            op_ready = 1'b1;
                            hi_d     = src1;
                        end else if (op_sel[OP_MTLO]) begin
                            op_ready = 1'b1;
                            lo_d     = src1;
                        end else begin
                            // empty op retires without touching HI/LO
                            op_ready = 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    // a flush here means the divider is never started
                    if (cancel) begin
                        state_d = ST_IDLE;
                    end else begin
                        div_in_valid = 1'b1;
                        state_d      = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    div_out_ready = 1'b1;
                    if (div_out_valid) begin
                        if (!cancel) begin
                            op_ready = 1'b1;
                            hi_d     = div_result[RES_HI_MSB:RES_HI_LSB];
                            lo_d     = div_result[RES_LO_MSB:RES_LO_LSB];
                        end
                        state_d = ST_IDLE;
                    end else if (cancel) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // swallow the orphaned result before accepting new work
                    div_out_ready = 1'b1;
                    if (div_out_valid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, HI/LO and divider operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hi_q     <= HILO_RST;
            lo_q     <= HILO_RST;
            div_op   <= 2'b00;
            dividend <= '0;
            divisor  <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (launch) begin
                div_op   <= {op_sel[OP_DIVU], op_sel[OP_DIV]};
                dividend <= src1;
                divisor  <= src2;
            end
        end
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- EX-stage owner of the HI/LO architectural registers.
- Sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage.
- Drives the combinational multiplier and the handshaked divider, and commits their 64-bit results to HI/LO.
- Stalls EX via op_ready while a divide is outstanding; drains an in-flight divide when EX is flushed.

Parameters:
HILO_RST, 32'h0, reset value of both HI and LO

Ports:
clk  in  1  clock
rst  in  1  reset rst, synchronous, active-high; clock clk
op_valid  in  1  EX holds a valid HI/LO-writing instruction
op  in  6  one-hot {mtlo,mthi,divu,div,multu,mult} (bit0=mult); held stable until op_ready or cancel
src1  in  32  rs value (dividend / multiplicand / MT data)
src2  in  32  rt value (divisor / multiplier)
cancel  in  1  EX flush (exception/eret); aborts current op
op_ready  out  1  op completes this cycle; EX may advance
hi_rdata  out  32  current HI (registered)
lo_rdata  out  32  current LO (registered)
busy  out  1  state != IDLE
mul_op  out  2  {unsigned,signed} to multiplier
mul_src1  out  32  = src1
mul_src2  out  32  = src2
mul_result  in  64  multiplier product {HI,LO}
div_op  out  2  {unsigned,signed}, registered, held LAUNCH..DRAIN
dividend  out  32  registered src1
divisor  out  32  registered src2
div_in_valid  out  1  one-cycle launch pulse
div_result  in  64  [63:32]=remainder->HI, [31:0]=quotient->LO
div_out_valid  in  1  divider result valid
div_out_ready  out  1  result accept

Behaviour:
- Reset: state IDLE; HI=LO=HILO_RST; div_op=0, dividend=divisor=0; div_in_valid=0, div_out_ready=0, op_ready=0, busy=0.
- FSM states: IDLE, LAUNCH, WAIT, DRAIN.
- IDLE:
  - op_valid & !cancel & (mult|multu|mthi|mtlo): op_ready=1 same cycle (combinational); HI/LO written at that edge.
    - mult/multu: {HI,LO}<=mul_result.
    - mthi: HI<=src1, LO unchanged.
    - mtlo: LO<=src1, HI unchanged.
  - op_valid & !cancel & (div|divu): op_ready=0; latch src1/src2 into dividend/divisor; div_op<={divu,div}; ->LAUNCH.
  - cancel, or op_valid=0: nothing accepted, no write.
- LAUNCH:
  - div_in_valid=1, op_ready=0; ->WAIT.
  - If cancel: div_in_valid forced 0; ->IDLE; divider never started.
- WAIT:
  - div_out_ready=1.
  - div_out_valid & !cancel: op_ready=1; {HI,LO}<=div_result at the edge; ->IDLE.
  - cancel & div_out_valid same cycle: result discarded; ->IDLE.
  - cancel & !div_out_valid: ->DRAIN.
- DRAIN:
  - div_out_ready=1, op_ready=0; new ops stall (op_valid ignored).
  - div_out_valid: discard; ->IDLE.
  - cancel in DRAIN has no extra effect.
- Operand stability: dividend/divisor/div_op come from registers and stay constant from LAUNCH until the handshake completes, because the divider samples them only on its internal tready.
- mul_op/mul_src are combinational from op/src, so the 1-cycle MULT commit needs no registers beyond HI/LO.
- Illegal multi-hot op: lowest set bit wins. op with no bit set: op_ready=1, no write.
- Divide by zero: whatever div_result returns is written; no trap.
- Read path: hi_rdata/lo_rdata always show committed registers. An MFHI/MFLO in EX the cycle after a commit sees the new value; no bypass needed.
- div_out_ready=0 in IDLE and LAUNCH.
- Reset mid-divide: unit returns to IDLE; the divider shares rst, so no drain is required.
- Latency:
  - mult/mt: 0 extra cycles.
  - div: 2 + divider latency cycles from accept to op_ready.

Decomposition:
- Shared package holds:
  - op bit indices (OP_MULT=0..OP_MTLO=5) and the 6-bit op width;
  - FSM state encodings (IDLE/LAUNCH/WAIT/DRAIN);
  - the div_result field split (HI=[63:32], LO=[31:0]).
- Single module, no sub-module. FSM and HI/LO registers are tightly coupled. Multiplier and divider are instantiated by the EX-stage top, not here.

Test Plan:
- Reset then MULT src1=32'hFFFFFFFF src2=2 -> op_ready=1 same cycle; next cycle HI=32'hFFFFFFFF, LO=32'hFFFFFFFE. MULTU same operands -> HI=1, LO=32'hFFFFFFFE.
- DIV src1=7 src2=32'hFFFFFFFE -> one div_in_valid pulse 1 cycle after accept; operands stable until result; on result op_ready=1, LO=32'hFFFFFFFD, HI=1.
- DIVU 32'hFFFFFFFF/16 -> LO=32'h0FFFFFFF, HI=32'hF; busy=1 from accept until the op_ready cycle inclusive-exclusive.
- MTHI 32'h12345678 then MTLO 32'hCAFEBABE on consecutive cycles -> both op_ready=1; HI=32'h12345678, LO=32'hCAFEBABE.
- DIV with cancel in the 3rd WAIT cycle -> state DRAIN; a following MULT is stalled (op_ready=0) until div_out_valid; HI/LO unchanged; MULT then completes.
- Cancel during LAUNCH -> div_in_valid never asserted; back to IDLE next cycle. rst asserted in WAIT -> HI=LO=0, busy=0 next cycle.
